tile_config_loader: RTL and testbench

TILE_CONFIG_LOADER -- requirements
Module: tile_config_loader

---
 rtl/tile_config_loader.sv | 140 ++++++++++++++
 tb/tb_tile_config_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tile_config_loader.sv
// Tile configuration loader: streams DW-bit words into a shadow register and commits them to conf.
// Optional feature macro CFG_CHECKSUM_EN adds a trailing XOR checksum word and the sticky err flag.
module tile_config_loader #(
    parameter int CONF_BITS = 96,
    parameter int DW        = 8,
    parameter int NWORDS    = (CONF_BITS + DW - 1) / DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DW-1:0]        cfg_data,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic [CONF_BITS-1:0] conf,
    output logic                 cset,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int CNTW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(NWORDS - 1);

`ifdef CFG_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, COMMIT, STROBE} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, COMMIT, STROBE} state_t;
`endif

    state_t                 state_q, state_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic [CONF_BITS-1:0]   shadow_q, shadow_d;
    logic [CONF_BITS-1:0]   conf_q, conf_d;
`ifdef CFG_CHECKSUM_EN
    logic                   err_q, err_d;
    logic [DW-1:0]          xor_q, xor_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        conf_d   = conf_q;
`ifdef CFG_CHECKSUM_EN
        err_d    = err_q;
        xor_d    = xor_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = '0;
`ifdef CFG_CHECKSUM_EN
                    err_d   = 1'b0;
                    xor_d   = '0;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cfg_valid) begin
                    // Bits beyond CONF_BITS in the last word have no home and are dropped
                    for (int i = 0; i < CONF_BITS; i++) begin
                        if (CNTW'(i / DW) == cnt_q) begin
                            shadow_d[i] = cfg_data[i % DW];
                        end
                    end
                    cnt_d = cnt_q + CNTW'(1);
`ifdef CFG_CHECKSUM_EN
                    xor_d = xor_q ^ cfg_data;
                    if (cnt_q == LAST) state_d = CHECK;
`else
                    if (cnt_q == LAST) state_d = COMMIT;
`endif
                end
            end
`ifdef CFG_CHECKSUM_EN
            CHECK: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cfg_valid) begin
                    if (cfg_data == xor_q) begin
                        state_d = COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            COMMIT: begin
                conf_d  = shadow_q;
                state_d = STROBE;
            end
            STROBE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            conf_q   <= '0;
`ifdef CFG_CHECKSUM_EN
            err_q    <= 1'b0;
            xor_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            conf_q   <= conf_d;
`ifdef CFG_CHECKSUM_EN
            err_q    <= err_d;
            xor_q    <= xor_d;
`endif
        end
    end

`ifdef CFG_CHECKSUM_EN
    assign cfg_ready = (state_q == LOAD) || (state_q == CHECK);
    assign err       = err_q;
`else
    assign cfg_ready = (state_q == LOAD);
    assign err       = 1'b0;
`endif
    assign busy = (state_q != IDLE);
    assign cset = (state_q == STROBE);
    assign done = (state_q == STROBE);
    assign conf = conf_q;

endmodule

// File: tb/tb_tile_config_loader.sv
// Directed plus randomized bench for tile_config_loader (CONF_BITS=20, DW=8, NWORDS=3).
// Expected conf is rebuilt arithmetically from the words sent; checksum path only with CFG_CHECKSUM_EN.
module tb_tile_config_loader;

    localparam int CB = 20;
    localparam int DW = 8;
    localparam int NW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [DW-1:0] cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CB-1:0] conf;
    logic          cset;
    logic          busy;
    logic          done;
    logic          err;

    int compared   = 0;
    int mismatched = 0;
    logic [CB-1:0] model_conf;

    tile_config_loader #(
        .CONF_BITS(CB),
        .DW       (DW),
        .NWORDS   (NW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .cfg_data (cfg_data),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .conf     (conf),
        .cset     (cset),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word k lands at weight 2^(8k); anything at or above 2^CB is lost.
    function automatic logic [CB-1:0] pack(input logic [7:0] w0,
                                           input logic [7:0] w1,
                                           input logic [7:0] w2);
        longint unsigned v;
        v = longint'(w0) + longint'(w1) * 256 + longint'(w2) * 65536;
        return CB'(v % (longint'(1) << CB));
    endfunction

    task automatic send_word(input logic [7:0] w, input int gap);
        for (int g = 0; g < gap; g++) begin
            cfg_valid = 1'b0;
            cfg_data  = 8'($urandom);
            start     = 1'($urandom_range(0, 1));
            tick();
            check("ready_in_gap", cfg_ready, 1);
            check("no_cset_in_gap", cset, 0);
        end
        start     = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = w;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input int gap,
                            input bit good_ck, input bit abort_commit);
        logic [CB-1:0] exp;
        logic [7:0]    ck;
        exp = pack(w0, w1, w2);
        ck  = good_ck ? (w0 ^ w1 ^ w2)
                      : ((w0 ^ w1 ^ w2) ^ 8'($urandom_range(1, 255)));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_cleared_by_start", err, 0);
        send_word(w0, gap);
        send_word(w1, gap);
        send_word(w2, gap);
`ifdef CFG_CHECKSUM_EN
        check("ready_in_check", cfg_ready, 1);
        check("busy_in_check", busy, 1);
        check("no_cset_in_check", cset, 0);
        send_word(ck, gap);
        if (!good_ck) begin
            check("err_set", err, 1);
            check("idle_after_bad_ck", busy, 0);
            check("no_cset_bad_ck", cset, 0);
            check("no_done_bad_ck", done, 0);
            check("conf_kept_bad_ck", conf, model_conf);
            tick();
            check("no_late_cset", cset, 0);
            check("err_sticky", err, 1);
            return;
        end
`else
        check("err_tied_low", err, {31'b0, ck[0] & 1'b0});
`endif
        check("commit_no_cset", cset, 0);
        check("commit_busy", busy, 1);
        check("commit_not_ready", cfg_ready, 0);
        check("conf_before_commit", conf, model_conf);
        abort = abort_commit;
        tick();
        abort = 1'b0;
        check("strobe_cset", cset, 1);
        check("strobe_done", done, 1);
        check("strobe_conf", conf, exp);
        check("strobe_not_ready", cfg_ready, 0);
        tick();
        check("cset_one_cycle", cset, 0);
        check("done_one_cycle", done, 0);
        check("idle_after_strobe", busy, 0);
        check("conf_held", conf, exp);
        model_conf = exp;
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = 8'hFF;
        model_conf = '0;
        tick();
        tick();
        check("rst_conf", conf, 0);
        check("rst_cset", cset, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_ready", cfg_ready, 0);
        rst       = 1'b1;
        cfg_valid = 1'b0;
        tick();
        check("idle_ignores_valid", busy, 0);

        run_load(8'hA5, 8'h3C, 8'hF7, 0, 1'b1, 1'b0);
        check("directed_conf", conf, 32'h73CA5);
        run_load(8'h5A, 8'hC3, 8'h0E, 0, 1'b1, 1'b0);
        run_load(8'hA5, 8'h3C, 8'hF7, 3, 1'b1, 1'b1);

        // abort with the second word; start in the same cycle is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        send_word(8'h11, 0);
        cfg_valid = 1'b1;
        cfg_data  = 8'h22;
        abort     = 1'b1;
        start     = 1'b1;
        tick();
        cfg_valid = 1'b0;
        abort     = 1'b0;
        start     = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_not_ready", cfg_ready, 0);
        check("abort_no_cset", cset, 0);
        check("abort_conf_kept", conf, model_conf);
        tick();
        check("start_in_abort_ignored", busy, 0);
        check("abort_no_late_cset", cset, 0);

        run_load(8'h01, 8'h02, 8'h04, 0, 1'b1, 1'b0);
        run_load(8'h01, 8'h02, 8'h04, 0, 1'b0, 1'b0);
        run_load(8'h81, 8'h42, 8'h24, 1, 1'b1, 1'b0);

        for (int n = 0; n < 12; n++) begin
            run_load(8'($urandom), 8'($urandom), 8'($urandom),
                     $urandom_range(0, 2), $urandom_range(0, 3) != 0,
                     1'($urandom_range(0, 1)));
        end

        // reset in the middle of a load
        start = 1'b1;
        tick();
        start = 1'b0;
        send_word(8'h99, 0);
        send_word(8'h77, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_conf = '0;
        check("midrst_conf", conf, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", cfg_ready, 0);
        tick();
        check("midrst_no_cset", cset, 0);
        run_load(8'h3E, 8'hD1, 8'h6B, 0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
